// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
// The memory accepts every request; responses come back in order.
interface fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_valid);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_valid);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one memory request in flight, and feeds the IF/ID
// register through a one-entry skid buffer. It stops after HLT and flushes on redirect.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_stage_if.master        imem,
    input  logic                 id_stall,
    input  logic                 redirect_valid,
    input  logic [15:0]          redirect_pc,
    output logic                 if_valid,
    output logic [15:0]          if_instr,
    output logic [15:0]          if_pc,
    output logic [15:0]          if_pc_plus2,
    output logic                 if_halted
);

    function automatic logic [15:0] pc_inc2(input logic [15:0] pc);
        return pc + 16'd2;
    endfunction

    logic        r_started;
    logic [15:0] r_pc;
    logic [15:0] r_req_pc;
    logic        r_outstanding;
    logic        r_discard;
    logic        r_skid_valid;
    logic [15:0] r_skid_instr;
    logic [15:0] r_skid_pc;
    logic        r_halted;
    logic        r_if_valid;
    logic [15:0] r_if_instr;
    logic [15:0] r_if_pc;
    logic [15:0] r_if_pc_plus2;

    logic w_resp;
    logic w_accept;
    logic w_resp_hlt;
    logic w_ifid_free;
    logic w_to_skid;
    logic w_issue;

    always_comb begin
        w_resp      = imem.imem_valid & r_outstanding & ~r_discard;
        // A response landing in a redirect cycle belongs to the old path and is dropped.
        w_accept    = w_resp & ~redirect_valid;
        w_resp_hlt  = w_resp & (imem.imem_rdata[15:12] == 4'hF);
        w_ifid_free = ~r_if_valid | ~id_stall;
        w_to_skid   = w_accept & ~r_skid_valid & ~w_ifid_free;
        w_issue     = r_started & ~r_halted & ~redirect_valid & ~r_discard & ~r_skid_valid &
                      (~r_outstanding | imem.imem_valid) & ~w_resp_hlt & ~w_to_skid;
    end

    assign imem.imem_req  = w_issue;
    assign imem.imem_addr = w_issue ? r_pc : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started     <= 1'b0;
            r_pc          <= RESET_PC;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_halted      <= 1'b0;
            r_if_valid    <= 1'b0;
            r_if_instr    <= 16'h0000;
            r_if_pc       <= 16'h0000;
            r_if_pc_plus2 <= 16'h0000;
        end else begin
            r_started <= 1'b1;

            if (w_issue) begin
                r_outstanding <= 1'b1;
            end else if (imem.imem_valid) begin
                r_outstanding <= 1'b0;
            end

            if (redirect_valid) begin
                r_pc         <= {redirect_pc[15:1], 1'b0};
                r_if_valid   <= 1'b0;
                r_skid_valid <= 1'b0;
                r_halted     <= 1'b0;
                if (r_outstanding && !imem.imem_valid) begin
                    r_discard <= 1'b1;
                end else if (imem.imem_valid) begin
                    r_discard <= 1'b0;
                end
            end else begin
                if (w_issue) begin
                    r_pc <= pc_inc2(r_pc);
                end
                if (w_resp_hlt) begin
                    r_halted <= 1'b1;
                end
                if (imem.imem_valid && r_discard) begin
                    r_discard <= 1'b0;
                end

                // The skid entry is older than any response, so it always drains first.
                if (w_ifid_free) begin
                    if (r_skid_valid) begin
                        r_if_valid    <= 1'b1;
                        r_if_instr    <= r_skid_instr;
                        r_if_pc       <= r_skid_pc;
                        r_if_pc_plus2 <= pc_inc2(r_skid_pc);
                        r_skid_valid  <= 1'b0;
                    end else if (w_accept) begin
                        r_if_valid    <= 1'b1;
                        r_if_instr    <= imem.imem_rdata;
                        r_if_pc       <= r_req_pc;
                        r_if_pc_plus2 <= pc_inc2(r_req_pc);
                    end else begin
                        r_if_valid    <= 1'b0;
                    end
                end else if (w_to_skid) begin
                    r_skid_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_req_pc <= r_pc;
        end
        if (w_to_skid) begin
            r_skid_instr <= imem.imem_rdata;
            r_skid_pc    <= r_req_pc;
        end
    end

    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_pc_plus2 = r_if_pc_plus2;
    assign if_halted   = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a main instance behind a latency-configurable memory model,
// plus a second instance with RESET_PC=16'hFFFE streaming from a 1-cycle memory.
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        id_stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        if_halted;

    logic        w_stall  = 1'b0;
    logic        w_redir  = 1'b0;
    logic [15:0] w_rpc    = 16'h0000;
    logic        w_if_valid;
    logic [15:0] w_if_instr;
    logic [15:0] w_if_pc;
    logic [15:0] w_if_pc_plus2;
    logic        w_if_halted;

    fetch_stage_if bus();
    fetch_stage_if bus_w();

    fetch_stage #(.RESET_PC(16'h0000)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus2    (if_pc_plus2),
        .if_halted      (if_halted)
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) u_dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus_w),
        .id_stall       (w_stall),
        .redirect_valid (w_redir),
        .redirect_pc    (w_rpc),
        .if_valid       (w_if_valid),
        .if_instr       (w_if_instr),
        .if_pc          (w_if_pc),
        .if_pc_plus2    (w_if_pc_plus2),
        .if_halted      (w_if_halted)
    );

    typedef struct {
        logic [15:0] addr;
        int          due;
    } req_t;

    logic [15:0] mem [0:32767];
    req_t        pend[$];
    int          ncyc;
    int          lat;
    logic        g_stray;
    logic        last_req;
    logic [15:0] last_addr;
    int          n_chk;
    int          n_err;

    logic        w_req_prev;
    logic [15:0] w_log [2];
    int          wn;
    logic        w_seen;
    logic [15:0] w_pc2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive this cycle's inputs, sample the request, then step past the edge.
    task automatic cyc(input logic stall, input logic redir, input logic [15:0] rpc);
        req_t        r;
        logic [15:0] a;
        id_stall       = stall;
        redirect_valid = redir;
        redirect_pc    = rpc;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 16'h0000;
        if (g_stray) begin
            bus.imem_valid = 1'b1;
            bus.imem_rdata = 16'hBEEF;
            g_stray        = 1'b0;
        end else if (pend.size() > 0 && pend[0].due <= ncyc) begin
            r = pend.pop_front();
            a = r.addr;
            bus.imem_valid = 1'b1;
            bus.imem_rdata = mem[a[15:1]];
        end
        bus_w.imem_valid = w_req_prev;
        bus_w.imem_rdata = 16'h0777;
        #1;
        last_req  = bus.imem_req;
        last_addr = bus.imem_addr;
        if (last_req) pend.push_back('{last_addr, ncyc + lat});
        if (bus_w.imem_req && wn < 2) begin
            w_log[wn] = bus_w.imem_addr;
            wn++;
        end
        w_req_prev = bus_w.imem_req;
        @(posedge clk);
        #1;
        ncyc++;
        if (w_if_valid && !w_seen) begin
            w_seen = 1'b1;
            w_pc2  = w_if_pc_plus2;
        end
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        id_stall         = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = 16'h0000;
        bus.imem_valid   = 1'b0;
        bus.imem_rdata   = 16'h0000;
        bus_w.imem_valid = 1'b0;
        bus_w.imem_rdata = 16'h0000;
        w_req_prev       = 1'b0;
        g_stray          = 1'b0;
        pend.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ncyc = 0;
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        wn     = 0;
        w_seen = 1'b0;
        w_pc2  = 16'hDEAD;
        lat    = 1;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h3000 + i[15:0];
        mem[0]     = 16'h0123;
        mem[1]     = 16'h1456;
        mem[2]     = 16'h2789;
        mem[8]     = 16'h6161;
        mem[16'h10] = 16'h7B7B;
        mem[16'h20] = 16'h5A5A;

        // Reset values while rst_n is held low
        rst_n            = 1'b0;
        id_stall         = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = 16'h0000;
        bus.imem_valid   = 1'b0;
        bus.imem_rdata   = 16'h0000;
        bus_w.imem_valid = 1'b0;
        bus_w.imem_rdata = 16'h0000;
        w_req_prev       = 1'b0;
        g_stray          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   bus.imem_req,  1'b0);
        check("rst_addr",  bus.imem_addr, 16'h0000);
        check("rst_valid", if_valid,      1'b0);
        check("rst_instr", if_instr,      16'h0000);
        check("rst_pc",    if_pc,         16'h0000);
        check("rst_pc2",   if_pc_plus2,   16'h0000);
        check("rst_halt",  if_halted,     1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ncyc = 0;

        // Straight line, 1-cycle memory
        cyc(1'b0, 1'b0, 16'h0);
        check("s_req0",  last_req,  1'b1);
        check("s_addr0", last_addr, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0);
        check("s_instr0", if_instr,    16'h0123);
        check("s_pc0",    if_pc,       16'h0000);
        check("s_pc2_0",  if_pc_plus2, 16'h0002);
        check("s_addr1",  last_addr,   16'h0002);
        cyc(1'b0, 1'b0, 16'h0);
        check("s_instr1", if_instr,    16'h1456);
        check("s_pc1",    if_pc,       16'h0002);
        check("s_pc2_1",  if_pc_plus2, 16'h0004);
        check("s_addr2",  last_addr,   16'h0004);
        cyc(1'b0, 1'b0, 16'h0);
        check("s_valid2", if_valid,    1'b1);
        check("s_instr2", if_instr,    16'h2789);
        check("s_pc2",    if_pc,       16'h0004);
        check("s_pc2_2",  if_pc_plus2, 16'h0006);

        // Wrap instance
        check("w_cnt",   wn,       2);
        check("w_addr0", w_log[0], 16'hFFFE);
        check("w_addr1", w_log[1], 16'h0000);
        check("w_seen",  w_seen,   1'b1);
        check("w_pc2",   w_pc2,    16'h0000);

        // Stall with skid capture
        do_reset();
        lat = 1;
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        check("k_first", if_instr, 16'h0123);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 16'h0);
            check("k_req",   last_req, 1'b0);
            check("k_instr", if_instr, 16'h0123);
            check("k_pc",    if_pc,    16'h0000);
        end
        cyc(1'b0, 1'b0, 16'h0);
        check("k_drain_instr", if_instr, 16'h1456);
        check("k_drain_pc",    if_pc,    16'h0002);
        check("k_drain_req",   last_req, 1'b0);
        cyc(1'b0, 1'b0, 16'h0);
        check("k_req4",   last_req,  1'b1);
        check("k_addr4",  last_addr, 16'h0004);
        check("k_empty",  if_valid,  1'b0);
        cyc(1'b0, 1'b0, 16'h0);
        check("k_instr4", if_instr,  16'h2789);
        check("k_pc4",    if_pc,     16'h0004);

        // Redirect with a request outstanding, 3-cycle memory
        do_reset();
        lat = 3;
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 16'h0);
        check("r_req6",  last_req,  1'b1);
        check("r_addr6", last_addr, 16'h0006);
        check("r_instr", if_instr,  16'h2789);
        check("r_valid", if_valid,  1'b1);
        cyc(1'b0, 1'b1, 16'h0041);
        check("r_flush", if_valid,  1'b0);
        check("r_noreq", last_req,  1'b0);
        for (int i = 11; i < 16; i++) begin
            cyc(1'b0, 1'b0, 16'h0);
            check("r_hold_valid", if_valid, 1'b0);
            check("r_req_slot",   last_req, (i == 13));
            if (i == 13) check("r_addr40", last_addr, 16'h0040);
        end
        cyc(1'b0, 1'b0, 16'h0);
        check("r_valid40", if_valid,    1'b1);
        check("r_instr40", if_instr,    16'h5A5A);
        check("r_pc40",    if_pc,       16'h0040);
        check("r_pc2_40",  if_pc_plus2, 16'h0042);

        // Halt on the word at 4, then resume through a redirect
        mem[2] = 16'hF000;
        do_reset();
        lat = 1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        check("h_req",   last_req,  1'b0);
        check("h_instr", if_instr,  16'hF000);
        check("h_pc",    if_pc,     16'h0004);
        check("h_halt",  if_halted, 1'b1);
        check("h_valid", if_valid,  1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 16'h0);
            check("h_req_idle",   last_req,  1'b0);
            check("h_halt_held",  if_halted, 1'b1);
            check("h_instr_held", if_instr,  16'hF000);
        end
        cyc(1'b0, 1'b1, 16'h0010);
        check("h_unhalt", if_halted, 1'b0);
        check("h_noreq",  last_req,  1'b0);
        cyc(1'b0, 1'b0, 16'h0);
        check("h_req10",  last_req,  1'b1);
        check("h_addr10", last_addr, 16'h0010);
        cyc(1'b0, 1'b0, 16'h0);
        check("h_instr10", if_instr, 16'h6161);
        check("h_pc10",    if_pc,    16'h0010);

        // Redirect, response and stall in the same cycle
        do_reset();
        lat = 1;
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        check("x_first", if_instr, 16'h0123);
        cyc(1'b1, 1'b1, 16'h0020);
        check("x_flush", if_valid, 1'b0);
        check("x_noreq", last_req, 1'b0);
        cyc(1'b0, 1'b0, 16'h0);
        check("x_req20",  last_req,  1'b1);
        check("x_addr20", last_addr, 16'h0020);
        check("x_empty",  if_valid,  1'b0);
        cyc(1'b0, 1'b0, 16'h0);
        check("x_instr20", if_instr, 16'h7B7B);
        check("x_pc20",    if_pc,    16'h0020);

        // Reset while a request is in flight, then a stray response
        do_reset();
        lat = 1;
        check("m_valid", if_valid,  1'b0);
        check("m_halt",  if_halted, 1'b0);
        g_stray = 1'b1;
        cyc(1'b0, 1'b0, 16'h0);
        check("m_req0",   last_req,  1'b1);
        check("m_addr0",  last_addr, 16'h0000);
        check("m_ignore", if_valid,  1'b0);
        cyc(1'b0, 1'b0, 16'h0);
        check("m_valid0", if_valid,  1'b1);
        check("m_instr0", if_instr,  16'h0123);
        check("m_pc0",    if_pc,     16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
